// File: rtl/nn_fetch_sequencer_if.sv
// Handshake bundle between the inference sequencer,
// the SDRAM loader and the compute engine.
interface nn_fetch_sequencer_if #(
  parameter int NUMLAYERS = 2
);
  logic                 start;
  logic                 abort;
  logic                 ld_get_image;
  logic                 ld_get_coeffs;
  logic [NUMLAYERS-1:0] ld_layer;
  logic                 ld_busy;
  logic                 cmp_start;
  logic [NUMLAYERS-1:0] cmp_layer;
  logic                 cmp_done;
  logic                 busy;
  logic                 done;
  logic                 error;
  logic [1:0]           err_code;

  modport master (
    input  start, abort, ld_busy, cmp_done,
    output ld_get_image, ld_get_coeffs, ld_layer,
    output cmp_start, cmp_layer,
    output busy, done, error, err_code
  );

  modport slave (
    output start, abort, ld_busy, cmp_done,
    input  ld_get_image, ld_get_coeffs, ld_layer,
    input  cmp_start, cmp_layer,
    input  busy, done, error, err_code
  );
endinterface

// File: rtl/nn_fetch_sequencer.sv
// Inference sequencer: one image fetch, then per layer a
// coefficient fetch and a compute pass, every wait timed out.
module nn_fetch_sequencer #(
  parameter int NUMLAYERS   = 2,
  parameter int LAYER_COUNT = 3,
  parameter int TBITS       = 16,
  parameter int ACK_TIMEOUT = 16,
  parameter int OP_TIMEOUT  = 65535
) (
  input logic                  clk,
  input logic                  reset_n,
  nn_fetch_sequencer_if.master bus
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_REQ_IMG,
    S_REQ_COEF,
    S_WAIT_ACK,
    S_WAIT_LOAD,
    S_CMP_START,
    S_WAIT_CMP,
    S_FINISH,
    S_ERROR
  } state_t;

  localparam logic [NUMLAYERS-1:0] LAST_L =
    NUMLAYERS'(LAYER_COUNT - 1);
  localparam logic [NUMLAYERS-1:0] ONE_L = 1;
  localparam logic [TBITS-1:0] ONE_T = 1;
  localparam logic [TBITS:0] ONE_W = 1;
  localparam logic [TBITS:0] ACK_LIM =
    (TBITS+1)'(ACK_TIMEOUT);
  localparam logic [TBITS:0] OP_LIM =
    (TBITS+1)'(OP_TIMEOUT);

  state_t               state_q, state_d;
  logic                 img_q, img_d;
  logic [NUMLAYERS-1:0] layer_q, layer_d;
  logic [TBITS-1:0]     cnt_q, cnt_d;
  logic [TBITS:0]       waited;
  logic [1:0]           code_d;

  logic                 get_img_d, get_coef_d;
  logic                 cmp_d, busy_d, done_d, err_d;
  logic [NUMLAYERS-1:0] lay_d;

  // cycles spent in the current state, this one included
  assign waited = {1'b0, cnt_q} + ONE_W;

  // state, phase, layer and timeout bookkeeping
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q           <= S_IDLE;
      img_q             <= 1'b0;
      layer_q           <= '0;
      cnt_q             <= '0;
      bus.ld_get_image  <= 1'b0;
      bus.ld_get_coeffs <= 1'b0;
      bus.ld_layer      <= '0;
      bus.cmp_start     <= 1'b0;
      bus.cmp_layer     <= '0;
      bus.busy          <= 1'b0;
      bus.done          <= 1'b0;
      bus.error         <= 1'b0;
      bus.err_code      <= '0;
    end else begin
      state_q           <= state_d;
      img_q             <= img_d;
      layer_q           <= layer_d;
      cnt_q             <= cnt_d;
      bus.ld_get_image  <= get_img_d;
      bus.ld_get_coeffs <= get_coef_d;
      bus.ld_layer      <= lay_d;
      bus.cmp_start     <= cmp_d;
      bus.cmp_layer     <= lay_d;
      bus.busy          <= busy_d;
      bus.done          <= done_d;
      bus.error         <= err_d;
      bus.err_code      <= code_d;
    end
  end

  // next state; abort outranks every other input
  always_comb begin
    state_d = state_q;
    img_d   = img_q;
    layer_d = layer_q;
    code_d  = bus.err_code;
    if (bus.abort) begin
      state_d = S_IDLE;
      code_d  = 2'd0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            state_d = S_REQ_IMG;
            layer_d = '0;
          end
        end
        S_REQ_IMG: begin
          state_d = S_WAIT_ACK;
          img_d   = 1'b1;
        end
        S_REQ_COEF: begin
          state_d = S_WAIT_ACK;
          img_d   = 1'b0;
        end
        S_WAIT_ACK: begin
          if (bus.ld_busy) begin
            state_d = S_WAIT_LOAD;
          end else if (waited == ACK_LIM) begin
            state_d = S_ERROR;
            code_d  = 2'd1;
          end
        end
        S_WAIT_LOAD: begin
          if (!bus.ld_busy) begin
            state_d = img_q ? S_REQ_COEF : S_CMP_START;
          end else if (waited == OP_LIM) begin
            state_d = S_ERROR;
            code_d  = 2'd2;
          end
        end
        S_CMP_START: state_d = S_WAIT_CMP;
        S_WAIT_CMP: begin
          if (bus.cmp_done) begin
            if (layer_q == LAST_L) begin
              state_d = S_FINISH;
            end else begin
              state_d = S_REQ_COEF;
              layer_d = layer_q + ONE_L;
            end
          end else if (waited == OP_LIM) begin
            state_d = S_ERROR;
            code_d  = 2'd3;
          end
        end
        S_FINISH: state_d = S_IDLE;
        S_ERROR:  state_d = S_ERROR;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  // Moore outputs decoded from the state being entered
  always_comb begin
    get_img_d  = (state_d == S_REQ_IMG);
    get_coef_d = (state_d == S_REQ_COEF);
    cmp_d      = (state_d == S_CMP_START);
    done_d     = (state_d == S_FINISH);
    err_d      = (state_d == S_ERROR);
    busy_d     = !(state_d inside {S_IDLE, S_ERROR});
    lay_d      = (state_d == S_REQ_COEF) ? layer_d
                                         : bus.ld_layer;
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (&cnt_q) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + ONE_T;
    end
  end

endmodule

// File: tb/tb_nn_fetch_sequencer.sv
// Scoreboard bench for nn_fetch_sequencer: expected pulses
// are queued by stimulus and popped by a negedge monitor.
module tb_nn_fetch_sequencer;
  localparam int NL      = 2;
  localparam int EV_IMG  = 0;
  localparam int EV_COEF = 1;
  localparam int EV_CMP  = 2;
  localparam int EV_DONE = 3;
  localparam int EV_ERR  = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  nn_fetch_sequencer_if #(.NUMLAYERS(NL)) b ();
  nn_fetch_sequencer_if #(.NUMLAYERS(NL)) c ();

  nn_fetch_sequencer #(
    .NUMLAYERS(NL), .LAYER_COUNT(3), .TBITS(16),
    .ACK_TIMEOUT(8), .OP_TIMEOUT(65535)
  ) u_dut (
    .clk(clk), .reset_n(reset_n), .bus(b)
  );

  nn_fetch_sequencer #(
    .NUMLAYERS(NL), .LAYER_COUNT(3), .TBITS(16),
    .ACK_TIMEOUT(16), .OP_TIMEOUT(100)
  ) u_to (
    .clk(clk), .reset_n(reset_n), .bus(c)
  );

  int n_total = 0;
  int n_pass  = 0;
  int exp_q[$];

  function automatic void chk(string name, int act, int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d want %0d", name, act, exp);
  endfunction

  function automatic void check_ev(int kind, int arg);
    int act = kind * 16 + arg;
    if (exp_q.size() == 0) begin
      n_total++;
      $display("FAIL unexpected_event: got %0d want none", act);
    end else begin
      chk("event", act, exp_q.pop_front());
    end
  endfunction

  // loader model for the main DUT
  logic ld_busy_b = 1'b0;
  int   lcnt_b = 0;
  bit   ld_en = 1'b1;
  assign b.ld_busy = ld_busy_b;
  always @(posedge clk) begin
    if (ld_en && (b.ld_get_image || b.ld_get_coeffs)) begin
      ld_busy_b <= 1'b1;
      if (b.ld_get_image) lcnt_b <= 63;
      else if (b.ld_layer == 2'd0) lcnt_b <= 2047;
      else if (b.ld_layer == 2'd1) lcnt_b <= 127;
      else lcnt_b <= 79;
    end else if (lcnt_b != 0) begin
      lcnt_b <= lcnt_b - 1;
    end else begin
      ld_busy_b <= 1'b0;
    end
  end

  // compute model for the main DUT
  logic cmp_done_b = 1'b0;
  int   ccnt_b = 0;
  assign b.cmp_done = cmp_done_b;
  always @(posedge clk) begin
    if (b.cmp_start) ccnt_b <= 10;
    else if (ccnt_b != 0) ccnt_b <= ccnt_b - 1;
    cmp_done_b <= (ccnt_b == 1);
  end

  // short loader and silent compute engine for u_to
  logic ld_busy_c = 1'b0;
  int   lcnt_c = 0;
  int   cs_cnt = 0;
  assign c.ld_busy = ld_busy_c;
  assign c.cmp_done = 1'b0;
  always @(posedge clk) begin
    if (c.ld_get_image || c.ld_get_coeffs) begin
      ld_busy_c <= 1'b1;
      lcnt_c    <= 3;
    end else if (lcnt_c != 0) begin
      lcnt_c <= lcnt_c - 1;
    end else begin
      ld_busy_c <= 1'b0;
    end
  end
  always @(negedge clk) if (c.cmp_start) cs_cnt <= cs_cnt + 1;

  // monitor: every pulse of the main DUT pops the scoreboard
  bit err_prev = 1'b0;
  always @(negedge clk) begin
    if (reset_n) begin
      if (b.ld_get_image) check_ev(EV_IMG, 0);
      if (b.ld_get_coeffs) check_ev(EV_COEF, int'(b.ld_layer));
      if (b.cmp_start) check_ev(EV_CMP, int'(b.cmp_layer));
      if (b.done) check_ev(EV_DONE, 0);
      if (b.error && !err_prev) check_ev(EV_ERR, int'(b.err_code));
    end
    err_prev <= b.error;
  end

  task automatic push_run(bit with_done);
    exp_q.push_back(EV_IMG * 16);
    for (int l = 0; l < 3; l++) begin
      exp_q.push_back(EV_COEF * 16 + l);
      exp_q.push_back(EV_CMP * 16 + l);
    end
    if (with_done) exp_q.push_back(EV_DONE * 16);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    b.start = 1'b1;
    @(negedge clk);
    b.start = 1'b0;
  endtask

  task automatic pulse_abort();
    b.abort = 1'b1;
    @(negedge clk);
    b.abort = 1'b0;
  endtask

  task automatic wait_done(string name);
    int n = 0;
    while (!b.done && n < 20000) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_done_seen"}, int'(b.done), 1);
    @(negedge clk);
    chk({name, "_busy_after_done"}, int'(b.busy), 0);
    chk({name, "_queue_drained"}, exp_q.size(), 0);
  endtask

  initial begin
    int n;
    b.start = 1'b0;
    b.abort = 1'b0;
    c.start = 1'b0;
    c.abort = 1'b0;
    #12;
    chk("rst_get_image", int'(b.ld_get_image), 0);
    chk("rst_get_coeffs", int'(b.ld_get_coeffs), 0);
    chk("rst_cmp_start", int'(b.cmp_start), 0);
    chk("rst_busy", int'(b.busy), 0);
    chk("rst_done", int'(b.done), 0);
    chk("rst_error", int'(b.error), 0);
    chk("rst_err_code", int'(b.err_code), 0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_busy", int'(b.busy), 0);

    // nominal inference
    push_run(1'b1);
    pulse_start();
    chk("s1_image_latency", int'(b.ld_get_image), 1);
    wait_done("s1");

    // start during layer-1 load is ignored
    push_run(1'b1);
    pulse_start();
    n = 0;
    while (!(b.ld_layer == 2'd1 && b.ld_busy) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("s4_in_l1_load", int'(b.ld_busy), 1);
    pulse_start();
    wait_done("s4");

    // abort together with last cmp_done: no done pulse
    push_run(1'b0);
    pulse_start();
    n = 0;
    while (!(b.cmp_done && b.cmp_layer == 2'd2) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("s5_l2_cmp_done", int'(b.cmp_done), 1);
    pulse_abort();
    chk("s5_busy_after_abort", int'(b.busy), 0);
    chk("s5_no_done", int'(b.done), 0);
    repeat (20) @(negedge clk);
    chk("s5_queue_drained", exp_q.size(), 0);
    push_run(1'b1);
    pulse_start();
    wait_done("s5_rerun");

    // ack timeout with a dead loader
    ld_en = 1'b0;
    exp_q.push_back(EV_IMG * 16);
    exp_q.push_back(EV_ERR * 16 + 1);
    pulse_start();
    n = 0;
    while (!b.error && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("s2_ack_timeout_cycles", n, 9);
    chk("s2_err_code", int'(b.err_code), 1);
    chk("s2_busy_in_error", int'(b.busy), 0);
    pulse_start();
    repeat (5) @(negedge clk);
    chk("s2_error_held", int'(b.error), 1);
    chk("s2_code_held", int'(b.err_code), 1);
    pulse_abort();
    chk("s2_error_cleared", int'(b.error), 0);
    chk("s2_code_cleared", int'(b.err_code), 0);
    chk("s2_queue_drained", exp_q.size(), 0);
    ld_en = 1'b1;

    // compute timeout on the short-timeout instance
    @(negedge clk);
    c.start = 1'b1;
    @(negedge clk);
    c.start = 1'b0;
    n = 0;
    while (!c.cmp_start && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("s3_cmp_start_seen", int'(c.cmp_start), 1);
    n = 0;
    while (!c.error && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("s3_cmp_timeout_cycles", n, 101);
    chk("s3_err_code", int'(c.err_code), 3);
    chk("s3_cmp_start_count", cs_cnt, 1);
    c.abort = 1'b1;
    @(negedge clk);
    c.abort = 1'b0;
    chk("s3_error_cleared", int'(c.error), 0);

    // async reset in the middle of the image load
    exp_q.push_back(EV_IMG * 16);
    pulse_start();
    n = 0;
    while (!(b.ld_busy && b.busy) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("s6_in_load", int'(b.ld_busy), 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("s6_busy", int'(b.busy), 0);
    chk("s6_error", int'(b.error), 0);
    chk("s6_done", int'(b.done), 0);
    chk("s6_pulses", int'({b.ld_get_image, b.ld_get_coeffs, b.cmp_start}), 0);
    chk("s6_ld_layer", int'(b.ld_layer), 0);
    chk("s6_cmp_layer", int'(b.cmp_layer), 0);
    chk("s6_err_code", int'(b.err_code), 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (100) @(negedge clk);
    chk("s6_idle_busy", int'(b.busy), 0);
    chk("s6_idle_error", int'(b.error), 0);
    chk("s6_queue_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
